// File: rtl/seg_scan_decoder_pkg.sv
// Shared constants and types for the 7-segment scan readback decoder.
// Segment patterns are active-high with bit0=a .. bit6=g.
package seg_scan_decoder_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam int DIG_UNITS     = 0;
  localparam int DIG_TENS      = 1;
  localparam int DIG_HUNDREDS  = 2;
  localparam int DIG_THOUSANDS = 3;
  localparam int NUM_DIGITS    = 4;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_e;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] bcd;
  } seg_dec_t;

  function automatic logic [13:0] bcd_frame_to_bin(input logic [15:0] d);
    return 14'(d[DIG_THOUSANDS*4 +: 4]) * 14'd1000
         + 14'(d[DIG_HUNDREDS*4  +: 4]) * 14'd100
         + 14'(d[DIG_TENS*4      +: 4]) * 14'd10
         + 14'(d[DIG_UNITS*4     +: 4]);
  endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7.sv
// Combinational 7-segment pattern to BCD decoder; blank reads as BCD 0 with
// the blank flag set, unknown patterns clear valid.
module seg7_to_bcd
  import seg_scan_decoder_pkg::*;
(
  input  logic [6:0] pattern,
  output seg_dec_t   dec
);

  always_comb begin
    dec = '{valid: 1'b1, blank: 1'b0, bcd: 4'd0};
    case (pattern)
      SEG_0:     dec.bcd = 4'd0;
      SEG_1:     dec.bcd = 4'd1;
      SEG_2:     dec.bcd = 4'd2;
      SEG_3:     dec.bcd = 4'd3;
      SEG_4:     dec.bcd = 4'd4;
      SEG_5:     dec.bcd = 4'd5;
      SEG_6:     dec.bcd = 4'd6;
      SEG_7:     dec.bcd = 4'd7;
      SEG_8:     dec.bcd = 4'd8;
      SEG_9:     dec.bcd = 4'd9;
      SEG_BLANK: dec.blank = 1'b1;
      default:   dec.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 4-digit 7-segment bus: settles each scanned
// digit, decodes it and publishes complete frames as BCD and binary.
//
// state  | meaning
// WAIT   | no usable (one-hot anode) sample; waiting for a scan slot
// SETTLE | counting identical samples of the latched slot before capture
// HOLD   | slot captured; ignore repeats until the bus changes
module seg_scan_decoder
  import seg_scan_decoder_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,       // must be >= 2
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  blank_mask,
  output logic [13:0] value,
  output logic        frame_valid,
  output logic        changed,
  output logic        seg_error,
  output logic        stalled
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX      = TO_W'(TIMEOUT_CYCLES);

  logic [6:0] seg_q1, seg_q2, seg_n;
  logic [3:0] an_q1, an_q2, an_n;
  logic       usable, same, capture;

  scan_state_e      state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       lat_an, lat_an_d;
  logic [6:0]       lat_seg, lat_seg_d;

  seg_dec_t    dec;
  logic [15:0] shadow_digits;
  logic [3:0]  shadow_blank;
  logic [3:0]  seen;
  logic        seen_full;
  logic [13:0] value_calc;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q1 <= '0;
      seg_q2 <= '0;
      an_q1  <= '0;
      an_q2  <= '0;
    end else begin
      seg_q1 <= seg;
      seg_q2 <= seg_q1;
      an_q1  <= an;
      an_q2  <= an_q1;
    end
  end

  assign seg_n  = (SEG_ACTIVE_LOW != 0) ? ~seg_q2 : seg_q2;
  assign an_n   = (AN_ACTIVE_LOW != 0) ? ~an_q2 : an_q2;
  assign usable = (an_n != 4'd0) && ((an_n & (an_n - 4'd1)) == 4'd0);
  assign same   = (an_n == lat_an) && (seg_n == lat_seg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_WAIT;
      cnt     <= '0;
      lat_an  <= '0;
      lat_seg <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      lat_an  <= lat_an_d;
      lat_seg <= lat_seg_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    lat_an_d  = lat_an;
    lat_seg_d = lat_seg;
    capture   = 1'b0;
    if (!usable) begin
      state_d = ST_WAIT;
      cnt_d   = '0;
    end else begin
      case (state)
        ST_WAIT: begin
          state_d   = ST_SETTLE;
          cnt_d     = CNT_W'(1);
          lat_an_d  = an_n;
          lat_seg_d = seg_n;
        end
        ST_SETTLE: begin
          if (same) begin
            cnt_d = cnt + 1'b1;
            if (cnt == SETTLE_LAST) begin
              capture = 1'b1;
              state_d = ST_HOLD;
            end
          end else begin
            cnt_d     = CNT_W'(1);
            lat_an_d  = an_n;
            lat_seg_d = seg_n;
          end
        end
        ST_HOLD: begin
          if (!same) begin
            state_d   = ST_SETTLE;
            cnt_d     = CNT_W'(1);
            lat_an_d  = an_n;
            lat_seg_d = seg_n;
          end
        end
        default: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // At capture the sample equals the latch, so decode the live sample.
  seg7_to_bcd u_seg7_to_bcd (
    .pattern (seg_n),
    .dec     (dec)
  );

  assign seen_full  = (seen == 4'b1111);
  assign value_calc = bcd_frame_to_bin(shadow_digits);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_digits <= '0;
      shadow_blank  <= '0;
      seen          <= '0;
      seg_error     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && an_n[i]) begin
          shadow_digits[i*4 +: 4] <= dec.bcd;
          shadow_blank[i]         <= dec.blank;
        end
      end
      // A capture in the clearing cycle belongs to the next frame.
      seen <= (seen_full ? 4'b0000 : seen) | (capture ? an_n : 4'b0000);
      if (capture && !dec.valid)
        seg_error <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      blank_mask  <= '0;
      value       <= '0;
      frame_valid <= 1'b0;
      changed     <= 1'b0;
    end else begin
      frame_valid <= seen_full;
      changed     <= 1'b0;
      if (seen_full) begin
        digits     <= shadow_digits;
        blank_mask <= shadow_blank;
        value      <= value_calc;
        changed    <= (value_calc != value);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (capture)
      to_cnt <= '0;
    else if (to_cnt != TO_MAX)
      to_cnt <= to_cnt + 1'b1;
  end

  assign stalled = (to_cnt == TO_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised scan stimulus against a digit-level model of the display readback.
module tb_seg_scan_decoder;

  localparam int TO    = 300;
  localparam int DWELL = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic [15:0] digits;
  logic [3:0]  blank_mask;
  logic [13:0] value;
  logic        frame_valid, changed, seg_error, stalled;

  seg_scan_decoder #(
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (TO),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .digits      (digits),
    .blank_mask  (blank_mask),
    .value       (value),
    .frame_valid (frame_valid),
    .changed     (changed),
    .seg_error   (seg_error),
    .stalled     (stalled)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  blank;
    int          value;
    logic        changed;
  } frame_t;

  frame_t     exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         frames_seen = 0;
  int         frames_exp = 0;
  logic [3:0] m_bcd[4];
  logic [3:0] m_blank;
  logic [3:0] m_seen;
  int         m_prev;
  logic       m_err;
  logic [6:0] seg_tab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [6:0] bad_tab[4] = '{7'h49, 7'h01, 7'h40, 7'h76};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_bcd[i] = 4'd0;
    m_blank = 4'd0;
    m_seen  = 4'd0;
    m_prev  = 0;
    m_err   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (frame_valid === 1'b1) begin
      frames_seen++;
      if (exp_q.size() > 0) begin
        frame_t f;
        f = exp_q.pop_front();
        chk("frame_digits", digits, f.digits);
        chk("frame_blank", blank_mask, f.blank);
        chk("frame_value", value, f.value);
        chk("frame_changed", changed, f.changed);
      end
    end
  endtask

  task automatic model_capture(input int slot, input logic [6:0] pat);
    int   d;
    logic found;
    frame_t f;
    d = 0;
    found = 1'b0;
    for (int k = 0; k < 10; k++)
      if (seg_tab[k] == pat) begin
        d = k;
        found = 1'b1;
      end
    m_bcd[slot]   = 4'(d);
    m_blank[slot] = (pat == 7'h00);
    m_seen[slot]  = 1'b1;
    if (!found && pat != 7'h00) m_err = 1'b1;
    if (m_seen == 4'hF) begin
      f.digits  = {m_bcd[3], m_bcd[2], m_bcd[1], m_bcd[0]};
      f.blank   = m_blank;
      f.value   = m_bcd[3] * 1000 + m_bcd[2] * 100 + m_bcd[1] * 10 + m_bcd[0];
      f.changed = (f.value != m_prev);
      exp_q.push_back(f);
      frames_exp++;
      m_prev = f.value;
      m_seen = 4'd0;
    end
  endtask

  // Show one digit (slot >= 0) or nothing (slot < 0) for a number of cycles.
  task automatic dwell(input int slot, input logic [6:0] pat, input int cycles);
    if (slot >= 0) begin
      model_capture(slot, pat);
      an = ~(4'b0001 << slot);
    end else begin
      an = 4'hF;
    end
    seg = ~pat;
    repeat (cycles) step();
    chk("frame_count", frames_seen, frames_exp);
    chk("seg_error", seg_error, m_err);
    if (slot >= 0) chk("stalled_active", stalled, 1'b0);
  endtask

  task automatic ghost();
    an  = ~(4'b0001 << $urandom_range(0, 3));
    seg = 7'($urandom);
    repeat ($urandom_range(1, 3)) step();
  endtask

  task automatic scan4(input logic [6:0] p3, input logic [6:0] p2,
                       input logic [6:0] p1, input logic [6:0] p0, input bit glitch);
    logic [6:0] p[4];
    p = '{p0, p1, p2, p3};
    for (int s = 0; s < 4; s++) begin
      if (glitch && $urandom_range(0, 2) == 0) ghost();
      dwell(s, p[s], $urandom_range(DWELL - 8, DWELL + 20));
    end
  endtask

  function automatic logic [6:0] rand_pat(input bit allow_bad);
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return seg_tab[$urandom_range(0, 9)];
    if (r < 18 || !allow_bad) return 7'h00;
    return bad_tab[$urandom_range(0, 3)];
  endfunction

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", digits, 16'h0);
    chk("rst_blank", blank_mask, 4'h0);
    chk("rst_value", value, 14'd0);
    chk("rst_frame_valid", frame_valid, 1'b0);
    chk("rst_changed", changed, 1'b0);
    chk("rst_seg_error", seg_error, 1'b0);
    chk("rst_stalled", stalled, 1'b0);
    rst_n = 1'b1;
    repeat (2) step();

    scan4(7'h3F, 7'h06, 7'h5B, 7'h4F, 1'b0);
    chk("dir_0123_digits", digits, 16'h0123);
    chk("dir_0123_value", value, 14'd123);

    scan4(7'h6F, 7'h6F, 7'h6F, 7'h6F, 1'b0);
    scan4(7'h6F, 7'h6F, 7'h6F, 7'h6F, 1'b1);
    chk("dir_9999_value", value, 14'd9999);

    for (int n = 0; n < 10; n++)
      scan4(rand_pat(0), rand_pat(0), rand_pat(0), rand_pat(0), 1'b1);

    dwell(-1, 7'h00, TO + 20);
    chk("stalled_idle", stalled, 1'b1);
    scan4(rand_pat(0), rand_pat(0), rand_pat(0), rand_pat(0), 1'b0);

    scan4(7'h06, 7'h5B, 7'h4F, 7'h49, 1'b0);
    chk("bad_seg_d0", digits[3:0], 4'd0);
    chk("bad_seg_blank0", blank_mask[0], 1'b0);
    scan4(7'h3F, 7'h3F, 7'h06, 7'h06, 1'b1);

    dwell(0, 7'h7D, DWELL);
    dwell(1, 7'h07, DWELL);
    rst_n = 1'b0;
    an = 4'hF;
    #1;
    chk("midrst_digits", digits, 16'h0);
    chk("midrst_value", value, 14'd0);
    chk("midrst_blank", blank_mask, 4'h0);
    chk("midrst_seg_error", seg_error, 1'b0);
    exp_q.delete();
    model_reset();
    frames_exp = frames_seen;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    scan4(7'h66, 7'h6D, 7'h7D, 7'h07, 1'b0);
    chk("midrst_value_after", value, 14'd4567);

    for (int n = 0; n < 8; n++)
      scan4(rand_pat(1), rand_pat(1), rand_pat(1), rand_pat(1), 1'b1);

    repeat (10) step();
    chk("final_frame_count", frames_seen, frames_exp);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
